// File: rtl/div_issue_unit.sv
// Single-entry issue buffer between the ROB/RS and the 64-bit divide unit, with CDB broadcast.
// Optional flush support is enabled by defining DIV_FLUSH_EN.
module div_issue_unit #(
  parameter int unsigned TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic             issue_signed,
  input  logic [63:0]      issue_a,
  input  logic [63:0]      issue_b,
  output logic             div_valid_in,
  input  logic             div_ready,
  output logic             div_signed,
  output logic [63:0]      div_dividend,
  output logic [63:0]      div_divisor,
  input  logic             div_valid_out,
  input  logic [63:0]      div_quotient,
  output logic             div_yumi,
  output logic             cdb_valid,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [63:0]      cdb_data
`ifdef DIV_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  localparam int unsigned DW = 64;
  localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};
  localparam logic [DW-1:0] INT_MIN  = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESULT, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [TAG_W-1:0]  tag_q;
  logic              signed_q;
  logic [DW-1:0]     a_q, b_q, result_q;
  logic              flush_c, accept_c, capture_c, div_zero_c, overflow_c, special_c;

`ifdef DIV_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  // Ops whose result is architecturally fixed bypass the divide unit entirely
  assign div_zero_c = (issue_b == '0);
  assign overflow_c = issue_signed & (issue_a == INT_MIN) & (issue_b == ALL_ONES);
  assign special_c  = div_zero_c | overflow_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs; flush overrides every other transition
  always_comb begin
    state_d      = state_q;
    issue_ready  = 1'b0;
    div_valid_in = 1'b0;
    div_yumi     = 1'b0;
    cdb_valid    = 1'b0;
    accept_c     = 1'b0;
    capture_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        issue_ready = ~flush_c;
        accept_c    = issue_valid & ~flush_c;
        if (accept_c) state_d = special_c ? S_RESULT : S_LAUNCH;
      end
      S_LAUNCH: begin
        if (flush_c) begin
          state_d = S_IDLE;
        end else begin
          div_valid_in = 1'b1;
          if (div_ready) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (div_valid_out) begin
          div_yumi  = 1'b1;
          capture_c = ~flush_c;
          state_d   = flush_c ? S_IDLE : S_RESULT;
        end else if (flush_c) begin
          state_d = S_DRAIN;
        end
      end
      S_RESULT: begin
        if (flush_c) begin
          state_d = S_IDLE;
        end else begin
          cdb_valid = 1'b1;
          if (cdb_grant) state_d = S_IDLE;
        end
      end
`ifdef DIV_FLUSH_EN
      S_DRAIN: begin
        if (div_valid_out) begin
          div_yumi = 1'b1;
          state_d  = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Op payload and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q    <= '0;
      signed_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else if (accept_c) begin
      tag_q    <= issue_tag;
      signed_q <= issue_signed;
      a_q      <= issue_a;
      b_q      <= issue_b;
      if (div_zero_c)      result_q <= ALL_ONES;
      else if (overflow_c) result_q <= INT_MIN;
    end else if (capture_c) begin
      result_q <= div_quotient;
    end
  end

  assign div_signed   = signed_q;
  assign div_dividend = a_q;
  assign div_divisor  = b_q;
  assign cdb_tag      = tag_q;
  assign cdb_data     = result_q;

endmodule

// File: tb/tb_div_issue_unit.sv
// Directed self-checking bench for div_issue_unit with a small behavioural divide unit.
module tb_div_issue_unit;
  localparam int unsigned TAG_W   = 6;
  localparam int          DIV_LAT = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             issue_valid, issue_ready, issue_signed;
  logic [TAG_W-1:0] issue_tag;
  logic [63:0]      issue_a, issue_b;
  logic             div_valid_in, div_ready, div_signed, div_valid_out, div_yumi;
  logic [63:0]      div_dividend, div_divisor, div_quotient;
  logic             cdb_valid, cdb_grant;
  logic [TAG_W-1:0] cdb_tag;
  logic [63:0]      cdb_data;
`ifdef DIV_FLUSH_EN
  logic             flush;
`endif

  int checks = 0;
  int errors = 0;
  int launch_cnt = 0;

  div_issue_unit #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
    .issue_signed(issue_signed), .issue_a(issue_a), .issue_b(issue_b),
    .div_valid_in(div_valid_in), .div_ready(div_ready), .div_signed(div_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_valid_out(div_valid_out),
    .div_quotient(div_quotient), .div_yumi(div_yumi),
    .cdb_valid(cdb_valid), .cdb_grant(cdb_grant), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
`ifdef DIV_FLUSH_EN
    , .flush(flush)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural divide unit: fixed latency, result held until yumi
  logic [63:0] m_q;
  int          m_cnt;
  logic        m_busy;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_cnt <= 0; div_valid_out <= 1'b0; div_quotient <= '0; m_q <= '0;
    end else if (!m_busy && div_valid_in && div_ready) begin
      m_busy <= 1'b1;
      m_cnt  <= DIV_LAT;
      m_q    <= div_signed ? 64'($signed(div_dividend) / $signed(div_divisor))
                           : div_dividend / div_divisor;
    end else if (m_busy && !div_valid_out) begin
      if (m_cnt == 1) begin
        div_valid_out <= 1'b1;
        div_quotient  <= m_q;
      end
      m_cnt <= m_cnt - 1;
    end else if (div_valid_out && div_yumi) begin
      div_valid_out <= 1'b0;
      m_busy        <= 1'b0;
    end
  end

  always @(posedge clk) if (!reset && div_valid_in && div_ready) launch_cnt++;

  task automatic issue_op(input logic [63:0] a, input logic [63:0] b,
                          input logic [TAG_W-1:0] tag, input logic sgn);
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++; $display("FAIL issue_ready_before_accept: got %b expected 1", issue_ready);
    end
    issue_valid = 1'b1; issue_a = a; issue_b = b; issue_tag = tag; issue_signed = sgn;
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  task automatic wait_cdb(input string name);
    int i;
    for (i = 0; i < 50 && cdb_valid !== 1'b1; i++) begin
      if (div_valid_out === 1'b1) begin
        checks++;
        if (div_yumi !== 1'b1) begin
          errors++; $display("FAIL %s_yumi: got %b expected 1", name, div_yumi);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (cdb_valid !== 1'b1) begin
      errors++; $display("FAIL %s_timeout: cdb_valid got %b expected 1", name, cdb_valid);
    end
  endtask

  task automatic check_cdb(input string name, input logic [TAG_W-1:0] tag, input logic [63:0] data);
    checks++;
    if (cdb_tag !== tag || cdb_data !== data) begin
      errors++;
      $display("FAIL %s_cdb: got tag %0d data %h expected tag %0d data %h", name, cdb_tag, cdb_data, tag, data);
    end
  endtask

  task automatic grant_op(input string name);
    cdb_grant = 1'b1;
    @(negedge clk);
    cdb_grant = 1'b0;
    checks++;
    if (issue_ready !== 1'b1 || cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_grant: got ready %b cdb_valid %b expected 1 0", name, issue_ready, cdb_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (issue_ready !== 1'b1 || cdb_valid !== 1'b0 || div_valid_in !== 1'b0 || div_yumi !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready %b cdb %b dvi %b yumi %b expected 1 0 0 0",
               issue_ready, cdb_valid, div_valid_in, div_yumi);
    end
    checks++;
    if (cdb_tag !== '0 || cdb_data !== '0 || div_dividend !== '0 || div_divisor !== '0) begin
      errors++;
      $display("FAIL reset_regs: got tag %h data %h a %h b %h expected all 0", cdb_tag, cdb_data, div_dividend, div_divisor);
    end
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    issue_op(64'd50, 64'd5, 6'd3, 1'b0);
    checks++;
    if (div_valid_in !== 1'b1 || div_dividend !== 64'd50 || div_divisor !== 64'd5 || issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL unsigned_launch: got dvi %b a %h b %h ready %b expected 1 32 5 0",
               div_valid_in, div_dividend, div_divisor, issue_ready);
    end
    wait_cdb("unsigned");
    check_cdb("unsigned", 6'd3, 64'd10);
    repeat (2) @(negedge clk);
    checks++;
    if (cdb_valid !== 1'b1) begin
      errors++; $display("FAIL unsigned_hold: cdb_valid got %b expected 1", cdb_valid);
    end
    grant_op("unsigned");
  endtask

  task automatic test_signed();
    issue_op(64'hFFFF_FFFF_FFFF_FFCE, 64'd5, 6'd7, 1'b1);
    checks++;
    if (div_valid_in !== 1'b1 || div_signed !== 1'b1) begin
      errors++; $display("FAIL signed_launch: got dvi %b signed %b expected 1 1", div_valid_in, div_signed);
    end
    wait_cdb("signed");
    check_cdb("signed", 6'd7, 64'hFFFF_FFFF_FFFF_FFF6);
    grant_op("signed");
  endtask

  task automatic test_special(input string name, input logic [63:0] a, input logic [63:0] b,
                              input logic sgn, input logic [TAG_W-1:0] tag, input logic [63:0] res);
    int l0;
    l0 = launch_cnt;
    issue_op(a, b, tag, sgn);
    checks++;
    if (cdb_valid !== 1'b1 || div_valid_in !== 1'b0) begin
      errors++; $display("FAIL %s_bypass: got cdb %b dvi %b expected 1 0", name, cdb_valid, div_valid_in);
    end
    check_cdb(name, tag, res);
    grant_op(name);
    checks++;
    if (launch_cnt !== l0) begin
      errors++; $display("FAIL %s_no_launch: launches got %0d expected %0d", name, launch_cnt, l0);
    end
  endtask

  task automatic test_unsigned_min_by_ones();
    issue_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd11, 1'b0);
    checks++;
    if (div_valid_in !== 1'b1 || cdb_valid !== 1'b0) begin
      errors++; $display("FAIL umin_normal: got dvi %b cdb %b expected 1 0", div_valid_in, cdb_valid);
    end
    wait_cdb("umin");
    check_cdb("umin", 6'd11, 64'd0);
    grant_op("umin");
  endtask

  task automatic test_back_to_back();
    logic [TAG_W-1:0] t0;
    logic [63:0]      d0;
    div_ready = 1'b0;
    issue_op(64'd100, 64'd7, 6'd12, 1'b0);
    repeat (3) begin
      checks++;
      if (div_valid_in !== 1'b1 || div_dividend !== 64'd100) begin
        errors++; $display("FAIL stall_launch: got dvi %b a %h expected 1 64", div_valid_in, div_dividend);
      end
      @(negedge clk);
    end
    div_ready = 1'b1;
    wait_cdb("stall");
    check_cdb("stall", 6'd12, 64'd14);
    t0 = cdb_tag; d0 = cdb_data;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (cdb_valid !== 1'b1 || cdb_tag !== t0 || cdb_data !== d0 || issue_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got valid %b tag %0d data %h ready %b expected 1 %0d %h 0",
                 i, cdb_valid, cdb_tag, cdb_data, issue_ready, t0, d0);
      end
    end
    // Offer the next op during the grant cycle; it must wait one cycle
    cdb_grant = 1'b1;
    issue_valid = 1'b1; issue_a = 64'd9; issue_b = 64'd3; issue_tag = 6'd1; issue_signed = 1'b0;
    @(negedge clk);
    cdb_grant = 1'b0;
    checks++;
    if (issue_ready !== 1'b1 || div_valid_in !== 1'b0 || cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_same_cycle: got ready %b dvi %b cdb %b expected 1 0 0", issue_ready, div_valid_in, cdb_valid);
    end
    @(negedge clk);
    issue_valid = 1'b0;
    checks++;
    if (issue_ready !== 1'b0 || div_valid_in !== 1'b1 || div_dividend !== 64'd9) begin
      errors++;
      $display("FAIL b2b_accept: got ready %b dvi %b a %h expected 0 1 9", issue_ready, div_valid_in, div_dividend);
    end
    wait_cdb("b2b");
    check_cdb("b2b", 6'd1, 64'd3);
    grant_op("b2b");
  endtask

  task automatic test_reset_mid_op();
    issue_op(64'd77, 64'd7, 6'd20, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (issue_ready !== 1'b1 || div_valid_in !== 1'b0 || cdb_valid !== 1'b0 || div_yumi !== 1'b0 ||
        div_dividend !== '0 || cdb_tag !== '0) begin
      errors++;
      $display("FAIL reset_mid: got ready %b dvi %b cdb %b yumi %b a %h tag %0d expected 1 0 0 0 0 0",
               issue_ready, div_valid_in, cdb_valid, div_yumi, div_dividend, cdb_tag);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (cdb_valid !== 1'b0 || issue_ready !== 1'b1) begin
      errors++; $display("FAIL reset_no_bcast: got cdb %b ready %b expected 0 1", cdb_valid, issue_ready);
    end
  endtask

`ifdef DIV_FLUSH_EN
  task automatic test_flush();
    int i;
    issue_op(64'd40, 64'd4, 6'd5, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (i = 0; i < 20 && div_valid_out !== 1'b1; i++) begin
      checks++;
      if (cdb_valid !== 1'b0 || issue_ready !== 1'b0) begin
        errors++; $display("FAIL drain_wait: got cdb %b ready %b expected 0 0", cdb_valid, issue_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (div_valid_out !== 1'b1 || div_yumi !== 1'b1 || cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_yumi: got dvo %b yumi %b cdb %b expected 1 1 0", div_valid_out, div_yumi, cdb_valid);
    end
    @(negedge clk);
    checks++;
    if (issue_ready !== 1'b1 || cdb_valid !== 1'b0) begin
      errors++; $display("FAIL drain_exit: got ready %b cdb %b expected 1 0", issue_ready, cdb_valid);
    end
    // Flush in S_RESULT drops the broadcast
    issue_op(64'd1, 64'd0, 6'd2, 1'b0);
    flush = 1'b1;
    #1;
    checks++;
    if (cdb_valid !== 1'b0) begin
      errors++; $display("FAIL flush_result: cdb_valid got %b expected 0", cdb_valid);
    end
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (issue_ready !== 1'b1 || cdb_valid !== 1'b0) begin
      errors++; $display("FAIL flush_result_exit: got ready %b cdb %b expected 1 0", issue_ready, cdb_valid);
    end
    // Flush in S_IDLE blocks acceptance
    flush = 1'b1; issue_valid = 1'b1; issue_a = 64'd8; issue_b = 64'd2;
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++; $display("FAIL flush_idle_ready: got %b expected 0", issue_ready);
    end
    @(negedge clk);
    flush = 1'b0; issue_valid = 1'b0;
    checks++;
    if (div_valid_in !== 1'b0 || cdb_valid !== 1'b0 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle_no_accept: got dvi %b cdb %b ready %b expected 0 0 1", div_valid_in, cdb_valid, issue_ready);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_signed = 1'b0; issue_tag = '0;
    issue_a = '0; issue_b = '0; div_ready = 1'b1; cdb_grant = 1'b0;
`ifdef DIV_FLUSH_EN
    flush = 1'b0;
`endif
    test_reset();
    test_unsigned();
    test_signed();
    test_special("divzero", 64'd12345, 64'd0, 1'b0, 6'd4, 64'hFFFF_FFFF_FFFF_FFFF);
    test_special("sdivzero", 64'hFFFF_FFFF_FFFF_FFCE, 64'd0, 1'b1, 6'd6, 64'hFFFF_FFFF_FFFF_FFFF);
    test_special("overflow", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 6'd9,
                 64'h8000_0000_0000_0000);
    test_unsigned_min_by_ones();
    test_back_to_back();
    test_reset_mid_op();
`ifdef DIV_FLUSH_EN
    test_flush();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_issue_unit.md
DIV_ISSUE_UNIT -- requirements
Module: div_issue_unit

Interface
REQ-001 The block SHALL have parameter TAG_W, default 6, width of the ROB tag carried with each divide op.
REQ-002 The block SHALL have the ports below: clk input 1 (sole clock, all state on posedge); reset input 1 (asynchronous, active-high).
REQ-003 The block SHALL have issue_valid input 1; issue_ready output 1; issue_tag input TAG_W; issue_signed input 1; issue_a input 64 (dividend); issue_b input 64 (divisor).
REQ-004 The block SHALL have div_valid_in output 1; div_ready input 1; div_signed output 1; div_dividend output 64; div_divisor output 64; div_valid_out input 1; div_quotient input 64; div_yumi output 1; all of these connect to the 64-bit divide unit.
REQ-005 The block SHALL have cdb_valid output 1; cdb_grant input 1; cdb_tag output TAG_W; cdb_data output 64 (result broadcast to the common data bus).
REQ-006 The block SHALL have flush input 1, present only when DIV_FLUSH_EN is defined.

Function
REQ-007 The block SHALL hold exactly one op, under FSM states S_IDLE, S_LAUNCH, S_WAIT, S_RESULT, S_DRAIN.
REQ-008 The block SHALL drive issue_ready = (state == S_IDLE); an op is accepted on a posedge with issue_valid & issue_ready, latching tag, signed flag and both operands.
REQ-009 The block SHALL treat an op with issue_b == 0 as special: result 64'hFFFF_FFFF_FFFF_FFFF, signed or unsigned.
REQ-010 The block SHALL treat an op with issue_signed & issue_a == 64'h8000_0000_0000_0000 & issue_b == all-ones as special: result 64'h8000_0000_0000_0000.
REQ-011 For a special op, the block SHALL go S_IDLE -> S_RESULT, with cdb_valid high the cycle after acceptance and the divide unit never started.
REQ-012 For a normal op, the block SHALL go S_IDLE -> S_LAUNCH.
REQ-013 In S_LAUNCH, the block SHALL drive div_valid_in = 1 with the latched operands and flag on div_dividend/div_divisor/div_signed; on a posedge with div_ready it SHALL go to S_WAIT; otherwise it stays.
REQ-014 div_valid_in SHALL be high only in S_LAUNCH.
REQ-015 div_dividend, div_divisor and div_signed SHALL hold stable from S_LAUNCH until the divide unit returns a result.
REQ-016 In S_WAIT, when div_valid_out is high, the block SHALL drive div_yumi = 1 combinationally that cycle, capture div_quotient into the result register, and go to S_RESULT.
REQ-017 div_yumi SHALL be 0 in every state except S_WAIT and S_DRAIN.
REQ-018 In S_RESULT, the block SHALL drive cdb_valid = 1 with cdb_tag/cdb_data stable; on a posedge with cdb_grant it SHALL go to S_IDLE.
REQ-019 cdb_tag and cdb_data SHALL not change while cdb_valid is high and cdb_grant is low.
REQ-020 A new op SHALL be accepted no earlier than the cycle after the grant (no same-cycle re-issue).
REQ-021 Minimum latency SHALL be 1 cycle for special ops; for normal ops, acceptance-to-cdb_valid SHALL be divide-unit latency + 2 cycles.
REQ-022 S_DRAIN SHALL be reachable only via flush (REQ-026).

Reset
REQ-023 Asserting reset SHALL immediately force state S_IDLE and clear cdb_valid, div_valid_in and div_yumi to 0; issue_ready SHALL be 1 after reset.
REQ-024 Reset SHALL clear the tag, operand and result registers to 0.
REQ-025 Reset mid-operation SHALL abandon the op with no broadcast; the divide unit is reset by the same reset.

Configuration
REQ-026 With DIV_FLUSH_EN defined, flush SHALL have priority over all other transitions:
- S_LAUNCH -> S_IDLE, with div_valid_in gated low that cycle.
- S_WAIT -> S_DRAIN, or S_IDLE directly if div_valid_out is high that cycle (yumi asserted, result discarded).
- S_RESULT -> S_IDLE with no broadcast; cdb_valid is forced low that cycle.
- S_IDLE: no acceptance; issue_ready is forced low that cycle.
- S_DRAIN: asserts div_yumi when div_valid_out is high, discards the quotient, returns to S_IDLE, and ignores further flush.
REQ-027 Without DIV_FLUSH_EN, the flush port and S_DRAIN logic SHALL be absent; every accepted op SHALL broadcast exactly once.

Verification
REQ-028 Unsigned 50/5, tag 3 -> S_LAUNCH, div handshake, cdb_valid with cdb_tag 3, cdb_data 10; held until cdb_grant.
REQ-029 Signed -50/5, tag 7 -> cdb_data 64'hFFFF_FFFF_FFFF_FFF6 (-10); div_signed was 1 during launch.
REQ-030 Unsigned 12345/0 -> cdb_valid the cycle after acceptance, cdb_data all-ones, div_valid_in never asserted.
REQ-031 Signed 64'h8000_0000_0000_0000 / -1 -> cdb_data 64'h8000_0000_0000_0000 one cycle after acceptance.
REQ-032 cdb_grant held low 20 cycles -> cdb_valid/cdb_tag/cdb_data stable; issue_ready low throughout; accepted the cycle after grant.
REQ-033 With DIV_FLUSH_EN: flush in S_WAIT -> S_DRAIN; on div_valid_out, div_yumi=1, no cdb_valid, issue_ready=1 next cycle; async reset mid-S_WAIT -> outputs cleared immediately.
